// File: rtl/ex_muldiv_pkg.sv
// Shared constants and types for the EX-stage multiply/divide unit.
package ex_muldiv_pkg;

   localparam int unsigned MD_ITERS = 32;

   localparam logic [5:0] OP_SPECIAL  = 6'h00;
   localparam logic [5:0] FUNCT_MFHI  = 6'h10;
   localparam logic [5:0] FUNCT_MTHI  = 6'h11;
   localparam logic [5:0] FUNCT_MFLO  = 6'h12;
   localparam logic [5:0] FUNCT_MTLO  = 6'h13;
   localparam logic [5:0] FUNCT_MULT  = 6'h18;
   localparam logic [5:0] FUNCT_MULTU = 6'h19;
   localparam logic [5:0] FUNCT_DIV   = 6'h1A;
   localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_BUSY = 2'd1,
      MD_DONE = 2'd2
   } md_state_e;

   // Per-operation control captured when a mul/div starts
   typedef struct packed {
      logic is_div;
      logic neg_p;   // negate product / quotient
      logic neg_r;   // negate remainder
   } md_ctl_t;

endpackage

// File: rtl/ex_muldiv_iter.sv
// Unsigned iterative core: shift-add multiply or restoring divide, one bit per cycle.
module muldiv_iter
   import ex_muldiv_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = MD_ITERS
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    step,
   input  logic                    is_div,
   input  logic [DATA_WIDTH-1:0]   a_mag,
   input  logic [DATA_WIDTH-1:0]   b_mag,
   output logic [2*DATA_WIDTH-1:0] acc_next_c,
   output logic                    last_c
);
   localparam int unsigned W     = DATA_WIDTH;
   localparam int unsigned CNT_W = $clog2(W);

   logic [2*W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [W:0]       sum;
   logic [W:0]       diff;

   // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
   always_comb begin
      sum  = {1'b0, acc_q[2*W-1:W]} + ({1'b0, b_mag} & {(W+1){acc_q[0]}});
      diff = acc_q[2*W-1:W-1] - {1'b0, b_mag};
      if (is_div) begin
         acc_next_c = diff[W] ? {acc_q[2*W-2:0], 1'b0}
                              : {diff[W-1:0], acc_q[W-2:0], 1'b1};
      end else begin
         acc_next_c = {sum, acc_q[W-1:1]};
      end
   end

   always_comb begin
      acc_d = acc_q;
      cnt_d = cnt_q;
      if (start) begin
         acc_d = {W'(0), a_mag};
         cnt_d = '0;
      end else if (step) begin
         acc_d = acc_next_c;
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   assign last_c = (cnt_q == CNT_W'(W - 1));

   always_ff @(posedge clk) begin
      if (!reset) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multiply/divide unit: decode, FSM, sign fix-up, HI/LO and pipeline stall.
module ex_muldiv
   import ex_muldiv_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = MD_ITERS
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [5:0]            opcode_in,
   input  logic [5:0]            function_in,
   input  logic [DATA_WIDTH-1:0] operand_a,
   input  logic [DATA_WIDTH-1:0] operand_b,
   input  logic                  flush,
   output logic                  stall_out,
   output logic                  busy_out,
   output logic                  result_sel,
   output logic [DATA_WIDTH-1:0] result_out,
   output logic [DATA_WIDTH-1:0] hi_out,
   output logic [DATA_WIDTH-1:0] lo_out
);
   localparam int unsigned W = DATA_WIDTH;

   md_state_e      state_q, state_d;
   logic [W-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic [W-1:0]   a_q, a_d, b_mag_q, b_mag_d;
   md_ctl_t        ctl_q, ctl_d;

   logic           special;
   logic           dec_mult, dec_multu, dec_div, dec_divu;
   logic           dec_mfhi, dec_mflo, dec_mthi, dec_mtlo;
   logic           dec_md, dec_signed, neg_a, neg_b;
   logic [W-1:0]   a_mag, b_mag;
   logic           start, step, last_c;
   logic [2*W-1:0] acc_next_c, prod;
   logic [W-1:0]   quot, rem;

   always_comb begin
      special    = (opcode_in == OP_SPECIAL);
      dec_mult   = special && (function_in == FUNCT_MULT);
      dec_multu  = special && (function_in == FUNCT_MULTU);
      dec_div    = special && (function_in == FUNCT_DIV);
      dec_divu   = special && (function_in == FUNCT_DIVU);
      dec_mfhi   = special && (function_in == FUNCT_MFHI);
      dec_mflo   = special && (function_in == FUNCT_MFLO);
      dec_mthi   = special && (function_in == FUNCT_MTHI);
      dec_mtlo   = special && (function_in == FUNCT_MTLO);
      dec_md     = dec_mult | dec_multu | dec_div | dec_divu;
      dec_signed = dec_mult | dec_div;
      neg_a      = dec_signed & operand_a[W-1];
      neg_b      = dec_signed & operand_b[W-1];
      a_mag      = neg_a ? -operand_a : operand_a;
      b_mag      = neg_b ? -operand_b : operand_b;
   end

   // Signed fix-up applied to the final iteration's value as it is written
   always_comb begin
      prod = ctl_q.neg_p ? -acc_next_c : acc_next_c;
      quot = ctl_q.neg_p ? -acc_next_c[W-1:0] : acc_next_c[W-1:0];
      rem  = ctl_q.neg_r ? -acc_next_c[2*W-1:W] : acc_next_c[2*W-1:W];
   end

   muldiv_iter #(.DATA_WIDTH(W)) u_iter (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .step       (step),
      .is_div     (ctl_q.is_div),
      .a_mag      (a_mag),
      .b_mag      (b_mag_q),
      .acc_next_c (acc_next_c),
      .last_c     (last_c)
   );

   always_comb begin
      state_d = state_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      a_d     = a_q;
      b_mag_d = b_mag_q;
      ctl_d   = ctl_q;
      start   = 1'b0;
      step    = 1'b0;
      case (state_q)
         MD_IDLE: begin
            if (!flush) begin
               if (dec_md) begin
                  a_d          = operand_a;
                  b_mag_d      = b_mag;
                  ctl_d.is_div = dec_div | dec_divu;
                  ctl_d.neg_p  = neg_a ^ neg_b;
                  ctl_d.neg_r  = neg_a;
                  start        = 1'b1;
                  state_d      = MD_BUSY;
               end else if (dec_mthi) begin
                  hi_d = operand_a;
               end else if (dec_mtlo) begin
                  lo_d = operand_a;
               end
            end
         end
         MD_BUSY: begin
            if (flush) begin
               state_d = MD_IDLE;
            end else begin
               step = 1'b1;
               if (last_c) begin
                  state_d = MD_DONE;
                  if (!ctl_q.is_div) begin
                     hi_d = prod[2*W-1:W];
                     lo_d = prod[W-1:0];
                  end else if (b_mag_q == '0) begin
                     hi_d = a_q;
                     lo_d = '1;
                  end else begin
                     hi_d = rem;
                     lo_d = quot;
                  end
               end
            end
         end
         MD_DONE: state_d = MD_IDLE;
         default: state_d = MD_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= MD_IDLE;
         hi_q    <= '0;
         lo_q    <= '0;
         a_q     <= '0;
         b_mag_q <= '0;
         ctl_q   <= '0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         a_q     <= a_d;
         b_mag_q <= b_mag_d;
         ctl_q   <= ctl_d;
      end
   end

   // Stall and busy are forced low while reset is held
   assign stall_out  = reset & ~flush &
                       (((state_q == MD_IDLE) & dec_md) | (state_q == MD_BUSY));
   assign busy_out   = reset & (state_q == MD_BUSY);
   assign result_sel = dec_mfhi | dec_mflo;
   assign result_out = dec_mfhi ? hi_q : (dec_mflo ? lo_q : '0);
   assign hi_out     = hi_q;
   assign lo_out     = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: vector table plus flush/reset/back-to-back sequences.
module tb_ex_muldiv;
   import ex_muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  opcode_in;
   logic [5:0]  function_in;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic        flush;
   logic        stall_out;
   logic        busy_out;
   logic        result_sel;
   logic [31:0] result_out;
   logic [31:0] hi_out;
   logic [31:0] lo_out;

   ex_muldiv dut (
      .clk         (clk),
      .reset       (reset),
      .opcode_in   (opcode_in),
      .function_in (function_in),
      .operand_a   (operand_a),
      .operand_b   (operand_b),
      .flush       (flush),
      .stall_out   (stall_out),
      .busy_out    (busy_out),
      .result_sel  (result_sel),
      .result_out  (result_out),
      .hi_out      (hi_out),
      .lo_out      (lo_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  funct;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      opcode_in   = 6'h00;
      function_in = f;
      operand_a   = a;
      operand_b   = b;
   endtask

   function automatic exp_t ref_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      exp_t        r;
      logic [63:0] p;
      longint      sa, sbv;
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      r.hi = '0;
      r.lo = '0;
      if (f == FUNCT_MULT) begin
         p = 64'(sa * sbv);
         r.hi = p[63:32];
         r.lo = p[31:0];
      end else if (f == FUNCT_MULTU) begin
         p = {32'h0, a} * {32'h0, b};
         r.hi = p[63:32];
         r.lo = p[31:0];
      end else if (b == 32'h0) begin
         r.hi = a;
         r.lo = 32'hFFFF_FFFF;
      end else if (f == FUNCT_DIV) begin
         r.lo = 32'(sa / sbv);
         r.hi = 32'(sa % sbv);
      end else begin
         r.lo = a / b;
         r.hi = a % b;
      end
      return r;
   endfunction

   // Hold one mul/div in EX until the stall drops, then compare HI/LO in DONE
   task automatic issue_md(input string name, input logic [5:0] f, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo);
      exp_t e;
      int   cyc;
      drive(f, a, b);
      e.hi = hi;
      e.lo = lo;
      sb.push_back(e);
      cyc = 0;
      forever begin
         @(negedge clk);
         if (!stall_out) break;
         cyc++;
         if (cyc > 100) break;
      end
      check({name, " stall cycles"}, 32'(cyc), 32'd33);
      e = sb.pop_front();
      check({name, " hi"}, hi_out, e.hi);
      check({name, " lo"}, lo_out, e.lo);
      @(posedge clk);
      #1;
   endtask

   task automatic read_hl(input string name, input logic [31:0] hi, input logic [31:0] lo);
      drive(FUNCT_MFHI, 32'h0, 32'h0);
      @(negedge clk);
      check({name, " mfhi sel"}, 32'(result_sel), 32'd1);
      check({name, " mfhi"}, result_out, hi);
      @(posedge clk);
      #1;
      drive(FUNCT_MFLO, 32'h0, 32'h0);
      @(negedge clk);
      check({name, " mflo"}, result_out, lo);
      @(posedge clk);
      #1;
      drive(6'h00, 32'h0, 32'h0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl[11];
      exp_t        e;
      logic [5:0]  fsel[4];
      logic [5:0]  f;
      logic [31:0] ra, rb;

      tbl[0]  = '{FUNCT_MULT,  32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
      tbl[1]  = '{FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
      tbl[2]  = '{FUNCT_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
      tbl[3]  = '{FUNCT_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
      tbl[4]  = '{FUNCT_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
      tbl[5]  = '{FUNCT_DIVU,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF};
      tbl[6]  = '{FUNCT_DIV,   32'hFFFF_FF9C, 32'd0,         32'hFFFF_FF9C, 32'hFFFF_FFFF};
      tbl[7]  = '{FUNCT_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
      tbl[8]  = '{FUNCT_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
      tbl[9]  = '{FUNCT_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3};
      tbl[10] = '{FUNCT_MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};

      fsel[0] = FUNCT_MULT;
      fsel[1] = FUNCT_MULTU;
      fsel[2] = FUNCT_DIV;
      fsel[3] = FUNCT_DIVU;

      // Reset state
      reset = 1'b0;
      flush = 1'b0;
      drive(6'h00, 32'h0, 32'h0);
      @(negedge clk);
      check("reset stall", 32'(stall_out), 32'd0);
      check("reset busy", 32'(busy_out), 32'd0);
      check("reset result_sel", 32'(result_sel), 32'd0);
      @(posedge clk);
      @(negedge clk);
      check("reset hi", hi_out, 32'h0);
      check("reset lo", lo_out, 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b1;

      foreach (tbl[i]) begin
         issue_md($sformatf("vec%0d", i), tbl[i].funct, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo);
         read_hl($sformatf("vec%0d", i), tbl[i].hi, tbl[i].lo);
      end

      for (int i = 0; i < 6; i++) begin
         f  = fsel[$urandom_range(0, 3)];
         ra = $urandom;
         rb = $urandom >> $urandom_range(0, 31);
         e  = ref_md(f, ra, rb);
         issue_md($sformatf("rnd%0d f=%h a=%h b=%h", i, f, ra, rb), f, ra, rb, e.hi, e.lo);
      end

      // MTHI/MTLO preload, then flush mid-divide
      drive(FUNCT_MTHI, 32'h1234_5678, 32'h0);
      @(negedge clk);
      check("mthi stall", 32'(stall_out), 32'd0);
      @(posedge clk);
      #1;
      drive(FUNCT_MTLO, 32'h1234_5678, 32'h0);
      @(posedge clk);
      #1;
      read_hl("preload", 32'h1234_5678, 32'h1234_5678);

      drive(FUNCT_DIV, 32'd1000, 32'd3);
      repeat (10) @(posedge clk);
      #1;
      flush = 1'b1;
      @(negedge clk);
      check("flush stall", 32'(stall_out), 32'd0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      drive(6'h00, 32'h0, 32'h0);
      @(negedge clk);
      check("flush busy", 32'(busy_out), 32'd0);
      check("flush hi", hi_out, 32'h1234_5678);
      check("flush lo", lo_out, 32'h1234_5678);
      @(posedge clk);
      #1;

      // Same, with reset mid-divide
      drive(FUNCT_DIV, 32'd1000, 32'd3);
      repeat (10) @(posedge clk);
      #1;
      reset = 1'b0;
      drive(6'h00, 32'h0, 32'h0);
      @(negedge clk);
      check("reset mid stall", 32'(stall_out), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      check("reset mid busy", 32'(busy_out), 32'd0);
      check("reset mid hi", hi_out, 32'h0);
      check("reset mid lo", lo_out, 32'h0);
      @(posedge clk);
      #1;

      // Flushed mul in IDLE must not start
      drive(FUNCT_MULT, 32'd9, 32'd9);
      flush = 1'b1;
      @(negedge clk);
      check("idle flush stall", 32'(stall_out), 32'd0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      drive(6'h00, 32'h0, 32'h0);
      @(negedge clk);
      check("idle flush busy", 32'(busy_out), 32'd0);
      check("idle flush lo", lo_out, 32'h0);
      check("nop result", result_out, 32'h0);
      @(posedge clk);
      #1;

      // Back-to-back multiplies
      issue_md("b2b first", FUNCT_MULT, 32'd3, 32'd4, 32'd0, 32'd12);
      issue_md("b2b second", FUNCT_MULT, 32'd5, 32'd6, 32'd0, 32'd30);
      read_hl("b2b", 32'd0, 32'd30);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative multiply/divide unit with the architectural HI/LO registers, located in the EX stage directly downstream of the ID/EX pipeline latch. It decodes R-type MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO from the latched opcode and function fields. It runs multiply/divide over 32 iterations and holds the front of the pipeline with `stall_out` until HI/LO are written. MFHI/MFLO results are returned combinationally to the EX result mux.

## Interface
- `DATA_WIDTH`, 32, operand, HI and LO width; the iteration count equals `DATA_WIDTH`.
- `clk`  in  1  pipeline clock; the only clock.
- `reset`  in  1  synchronous, active-low reset (0 = reset).
- `opcode_in`  in  6  opcode from the ID/EX latch.
- `function_in`  in  6  function field from the ID/EX latch.
- `operand_a`  in  DATA_WIDTH  forwarded rs value.
- `operand_b`  in  DATA_WIDTH  forwarded rt value.
- `flush`  in  1  misprediction kill. Aborts any operation; an op in EX does not start.
- `stall_out`  out  1  holds PC, IF/ID and ID/EX.
- `busy_out`  out  1  high in state BUSY.
- `result_sel`  out  1  the EX instruction is MFHI/MFLO; the EX mux selects `result_out`.
- `result_out`  out  DATA_WIDTH  HI for MFHI, LO for MFLO, 0 otherwise.
- `hi_out`, `lo_out`  out  DATA_WIDTH  current HI/LO, for debug.

## Operation
- Decode applies only when `opcode_in` = 0. The op codes are MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B, MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13.
- The state machine has three states: IDLE, BUSY and DONE.
- **IDLE**
  - If a mul/div op is decoded and `flush` = 0:
    - Capture the operand magnitudes, the sign flags and the op kind.
    - Clear the counter and go to BUSY.
  - MTHI/MTLO with `flush` = 0 write HI or LO at the edge and stay in IDLE.
- **BUSY**
  - Each cycle performs one iteration.
  - Multiply: shift-add, 1 bit per cycle.
  - Divide: restoring, 1 quotient bit per cycle.
  - After iteration 31, write HI/LO at that edge and go to DONE.
- **DONE**
  - `stall_out` = 0 and the latch advances. The same instruction is still in EX this cycle and must not restart.
  - Go to IDLE unconditionally.
- Signed results:
  - The unsigned magnitude core runs on |a| and |b|.
  - The 64-bit product is negated if sign(a) ≠ sign(b).
  - The quotient sign is sign(a) XOR sign(b); the remainder sign equals sign(a).
- Result mapping: MULT/MULTU write HI = product[63:32] and LO = product[31:0]. DIV/DIVU write LO = quotient and HI = remainder.
- Divide by zero (both DIV and DIVU) writes LO = 0xFFFFFFFF and HI = `operand_a` as captured. Latency is unchanged.
- 0x80000000 DIV 0xFFFFFFFF gives LO = 0x80000000 and HI = 0; no trap is raised.
- `flush` in any state:
  - Next state is IDLE.
  - HI/LO are unchanged and no MTHI/MTLO write occurs.
  - `stall_out` = 0 in that cycle.
- `stall_out` = (IDLE ∧ mul/div decoded ∧ ¬flush) ∨ (BUSY ∧ ¬flush).
- `result_sel` is asserted for MFHI/MFLO in any state. It is only architecturally meaningful in IDLE or DONE.

## Timing
- Reset (`reset` = 0 at an edge) sets state IDLE, counter 0, HI = LO = 0 and clears the capture registers.
- During reset, `stall_out`, `busy_out` and `result_sel` are 0 whenever the decode inputs are 0.
- Reset has priority over `flush` and over an operation in flight. A reset mid-BUSY discards the partial result and clears HI/LO to 0.
- A mul/div occupies EX for 34 cycles, counting from the cycle it enters EX:
  - Cycle 0 (IDLE): `stall_out` = 1.
  - Cycles 1–32 (BUSY): `stall_out` = 1.
  - Cycle 33 (DONE): `stall_out` = 0.
- HI/LO are valid from cycle 33. An MFHI/MFLO entering EX on the next cycle reads the new values; no extra interlock is needed.
- Back-to-back mul/div: the second op enters EX in IDLE and restarts immediately, with no idle gap beyond DONE.
- MTHI/MTLO has 1-cycle latency and no stall. A following MFHI/MFLO sees the new value.

## Structure
- Add to `mips_pkg.vh`:
  - Constants `FUNCT_MULT`, `FUNCT_MULTU`, `FUNCT_DIV`, `FUNCT_DIVU`, `FUNCT_MFHI`, `FUNCT_MTHI`, `FUNCT_MFLO`, `FUNCT_MTLO`.
  - State encodings `MD_IDLE`, `MD_BUSY`, `MD_DONE`.
  - `MD_ITERS`.
- One sub-module, `muldiv_iter`, holds the 64-bit accumulator/remainder, the counter and the per-cycle shift-add / shift-subtract step. `ex_muldiv` keeps the FSM, decode, sign handling, HI/LO and stall logic.

## Test plan
- **Signed multiply:** MULT a = 7, b = 0xFFFFFFFD (−3) → `stall_out` high for 33 cycles; then HI = 0xFFFFFFFF, LO = 0xFFFFFFEB; MFLO next returns 0xFFFFFFEB.
- **Unsigned multiply and divide:**
  - MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001.
  - DIVU 100 / 7 → LO = 14, HI = 2.
- **Signed divide:**
  - DIV 0xFFFFFFF9 (−7) / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- **Divide by zero:** DIVU 100 / 0 → LO = 0xFFFFFFFF, HI = 100, after a 33-cycle stall.
- **Flush and reset:**
  - Preload HI = LO = 0x12345678 with MTHI/MTLO. Start DIV, assert `flush` in BUSY cycle 10 → `stall_out` drops that cycle; HI/LO stay 0x12345678; state is IDLE.
  - Repeat with `reset` = 0 instead of `flush` → HI = LO = 0.
- **Back-to-back ops:** MULT 3×4 followed directly by MULT 5×6, then MFLO → each op stalls 33 cycles and is separated only by its DONE cycle; the first product's LO = 12; MFLO returns 30.
